// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters and the shared ALU arbiter
interface alu_arbiter_if #(
  parameter int WIDTH = 64
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_A0;
  logic [WIDTH-1:0] req_A1;
  logic [WIDTH-1:0] req_B0;
  logic [WIDTH-1:0] req_B1;
  logic [2:0]       req_cntrl0;
  logic [2:0]       req_cntrl1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_err;

  modport master (
    output req_valid, req_A0, req_A1, req_B0, req_B1, req_cntrl0, req_cntrl1, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_A0, req_A1, req_B0, req_B1, req_cntrl0, req_cntrl1, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter around one shared 64-bit ALU (IDLE/EXEC/RESP)
// ALU_ARB_FIXED_PRI_EN: port 0 always wins ties instead of round robin.
module alu_arbiter #(
  parameter int WIDTH     = 64,
  parameter bit START_PRI = 1'b0
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  logic [1:0]       state_q, state_d;
  logic             id_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       cntrl_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;

  logic             gnt_port;
  logic             accept;

`ifdef ALU_ARB_FIXED_PRI_EN
  always_comb gnt_port = ~bus.req_valid[0];
`else
  logic ptr_q;

  always_comb begin
    if (&bus.req_valid) gnt_port = ptr_q;
    else                gnt_port = bus.req_valid[1];
  end

  always_ff @(posedge clk) begin
    if (reset)       ptr_q <= START_PRI;
    else if (accept) ptr_q <= ~gnt_port;
  end
`endif

  assign accept        = (state_q == S_IDLE) && (|bus.req_valid);
  assign bus.req_ready = accept ? (gnt_port ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_valid = (state_q == S_RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;

  // Subtraction reuses the adder as A + ~B + 1 so carry_out is the true bit-WIDTH carry.
  logic [WIDTH-1:0] opb, alu_y;
  logic [WIDTH:0]   sum;
  logic             is_sub, arith, alu_ill, alu_ovf, alu_cout;

  always_comb begin
    is_sub  = (cntrl_q == 3'b011);
    opb     = is_sub ? ~b_q : b_q;
    sum     = {1'b0, a_q} + {1'b0, opb} + {{WIDTH{1'b0}}, is_sub};
    alu_y   = '0;
    arith   = 1'b0;
    alu_ill = 1'b0;
    case (cntrl_q)
      3'b000:         alu_y = b_q;
      3'b010, 3'b011: begin
        alu_y = sum[WIDTH-1:0];
        arith = 1'b1;
      end
      3'b100:         alu_y = a_q & b_q;
      3'b101:         alu_y = a_q | b_q;
      3'b110:         alu_y = a_q ^ b_q;
      default:        alu_ill = 1'b1;
    endcase
    alu_ovf  = arith && (a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    alu_cout = arith && sum[WIDTH];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready[id_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cntrl_q  <= 3'b000;
      result_q <= '0;
      flags_q  <= 4'b0000;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q    <= gnt_port;
        a_q     <= gnt_port ? bus.req_A1 : bus.req_A0;
        b_q     <= gnt_port ? bus.req_B1 : bus.req_B0;
        cntrl_q <= gnt_port ? bus.req_cntrl1 : bus.req_cntrl0;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_ill ? '0 : alu_y;
        flags_q  <= alu_ill ? 4'b0000 : {alu_y[WIDTH-1], (alu_y == '0), alu_ovf, alu_cout};
        err_q    <= alu_ill;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against an arithmetic reference model
module tb_alu_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_arbiter_if #(.WIDTH(64)) bus ();

  alu_arbiter #(.WIDTH(64), .START_PRI(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a_r [2];
  logic [63:0] b_r [2];
  logic [2:0]  c_r [2];
  logic [1:0]  pend;
  logic        exp_ptr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  // Reference: ideal signed/unsigned arithmetic decides carry and overflow.
  function automatic void model_alu(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic [3:0] f, output logic e);
    logic [64:0]        u;
    logic signed [65:0] s;
    logic               ovf, cout, arith;
    r = '0; ovf = 1'b0; cout = 1'b0; arith = 1'b0; e = 1'b0; u = '0; s = '0;
    case (c)
      3'b000: r = b;
      3'b010: begin
        u = {1'b0, a} + {1'b0, b};
        s = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        arith = 1'b1;
      end
      3'b011: begin
        u = {1'b0, a} + {1'b0, ~b} + 65'd1;
        s = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
        arith = 1'b1;
      end
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: r = a ^ b;
      default: e = 1'b1;
    endcase
    if (arith) begin
      r    = u[63:0];
      cout = u[64];
      ovf  = (s != $signed({{2{r[63]}}, r}));
    end
    f = e ? 4'b0000 : {r[63], (r == 64'd0), ovf, cout};
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic set_req(input int p, input logic [2:0] c, input logic [63:0] a, input logic [63:0] b);
    c_r[p] = c; a_r[p] = a; b_r[p] = b; pend[p] = 1'b1;
  endtask

  task automatic rand_req(input int p);
    set_req(p, 3'($urandom_range(0, 7)), rand_val(), rand_val());
  endtask

  task automatic drive();
    bus.req_valid  = pend;
    bus.req_A0     = a_r[0]; bus.req_B0 = b_r[0]; bus.req_cntrl0 = c_r[0];
    bus.req_A1     = a_r[1]; bus.req_B1 = b_r[1]; bus.req_cntrl1 = c_r[1];
  endtask

  task automatic do_reset();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    pend          = 2'b00;
    reset         = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    exp_ptr = 1'b0;
    #1;
    check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_result", bus.rsp_result, 64'd0);
    check_eq("rst_flags", 64'(bus.rsp_flags), 64'd0);
    check_eq("rst_err", 64'(bus.rsp_err), 64'd0);
  endtask

  // One full transaction from IDLE; pend must have at least one bit set.
  task automatic run_op(input int hold, input logic oth_rdy, output logic g,
                        output logic [63:0] res, output logic [3:0] fl, output logic er);
    logic [63:0] er_r;
    logic [3:0]  ef;
    logic        ee;
    drive();
    #1;
`ifdef ALU_ARB_FIXED_PRI_EN
    g = pend[0] ? 1'b0 : 1'b1;
`else
    g = (pend == 2'b11) ? exp_ptr : pend[1];
    exp_ptr = ~g;
`endif
    check_eq("grant_ready", 64'(bus.req_ready), 64'(oh(g)));
    model_alu(c_r[g], a_r[g], b_r[g], er_r, ef, ee);
    @(posedge clk);
    @(negedge clk);
    pend[g] = 1'b0;
    bus.req_valid = pend;
    check_eq("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("exec_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(oh(g)));
    check_eq("rsp_result", bus.rsp_result, er_r);
    check_eq("rsp_flags", 64'(bus.rsp_flags), 64'(ef));
    check_eq("rsp_err", 64'(bus.rsp_err), 64'(ee));
    res = bus.rsp_result; fl = bus.rsp_flags; er = bus.rsp_err;
    for (int k = 0; k < hold; k++) begin
      bus.rsp_ready = oth_rdy ? oh(~g) : 2'b00;
      @(posedge clk);
      @(negedge clk);
      check_eq("hold_rsp_valid", 64'(bus.rsp_valid), 64'(oh(g)));
      check_eq("hold_result", bus.rsp_result, er_r);
      check_eq("hold_flags", 64'(bus.rsp_flags), 64'(ef));
      check_eq("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = oh(g);
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    check_eq("rsp_drop", 64'(bus.rsp_valid), 64'd0);
  endtask

  logic        g;
  logic [63:0] res;
  logic [3:0]  fl;
  logic        er;

  initial begin
    checks = 0; errors = 0;
    for (int p = 0; p < 2; p++) begin a_r[p] = '0; b_r[p] = '0; c_r[p] = '0; end
    pend = 2'b00; exp_ptr = 1'b0;
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    bus.req_A0 = '0; bus.req_A1 = '0; bus.req_B0 = '0; bus.req_B1 = '0;
    bus.req_cntrl0 = '0; bus.req_cntrl1 = '0;
    do_reset();

    set_req(0, 3'b010, 64'd1, 64'd1);
    set_req(1, 3'b011, 64'd5, 64'd3);
    run_op(0, 1'b0, g, res, fl, er);
    check_eq("t1_gnt0", 64'(g), 64'd0);
    check_eq("t1_res0", res, 64'd2);
    check_eq("t1_fl0", 64'(fl), 64'h0);
    run_op(1, 1'b1, g, res, fl, er);
    check_eq("t1_gnt1", 64'(g), 64'd1);
    check_eq("t1_res1", res, 64'd2);
    check_eq("t1_fl1", 64'(fl), 64'h1);
    do_reset();

    set_req(1, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    run_op(0, 1'b0, g, res, fl, er);
    check_eq("t2_res_add", res, 64'h8000_0000_0000_0000);
    check_eq("t2_fl_add", 64'(fl), 64'b1010);
    set_req(0, 3'b110, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    run_op(0, 1'b0, g, res, fl, er);
    check_eq("t2_res_xor", res, 64'd0);
    check_eq("t2_fl_xor", 64'(fl), 64'b0100);

    set_req(0, 3'b010, {64{1'b1}}, 64'd1);
    run_op(5, 1'b1, g, res, fl, er);
    check_eq("t3_res", res, 64'd0);
    check_eq("t3_fl", 64'(fl), 64'b0101);

    set_req(0, 3'b111, 64'd5, 64'd3);
    run_op(0, 1'b0, g, res, fl, er);
    check_eq("t4_err", 64'(er), 64'd1);
    check_eq("t4_res", res, 64'd0);
    check_eq("t4_fl", 64'(fl), 64'h0);

    do_reset();
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 6; i++) begin
      run_op(0, 1'b0, g, res, fl, er);
`ifdef ALU_ARB_FIXED_PRI_EN
      check_eq("t5_gnt", 64'(g), 64'd0);
`else
      check_eq("t5_gnt", 64'(g), 64'(i % 2));
`endif
      rand_req(int'(g));
    end

    do_reset();
    set_req(0, 3'b010, 64'd10, 64'd20);
    drive();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    pend = 2'b00;
    bus.req_valid = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_ptr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    set_req(1, 3'b011, 64'd3, 64'd5);
    run_op(0, 1'b0, g, res, fl, er);
    check_eq("t6_res", res, 64'hFFFF_FFFF_FFFF_FFFE);
    check_eq("t6_fl", 64'(fl), 64'b1000);

    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) rand_req(p);
      if (pend == 2'b00) rand_req(int'($urandom_range(0, 1)));
      run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), g, res, fl, er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
